// File: rtl/nec_ir_pkg.sv
// rtl/nec_ir_pkg.sv - shared frame type and controller state encoding for the NEC IR receive path
package nec_ir_pkg;

    typedef struct packed {
        logic       rep;
        logic [7:0] addr;
        logic [7:0] data;
    } nec_ir_frame_t;

    localparam int FRAME_W = $bits(nec_ir_frame_t);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        LATCH = 2'd1,
        RUN   = 2'd2
    } nec_ir_rx_state_e;

endpackage

// File: rtl/nec_ir_rx_fifo.sv
// rtl/nec_ir_rx_fifo.sv - frame FIFO with push/pop/flush, level and drop indication
module nec_ir_rx_fifo
    import nec_ir_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [FRAME_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [FRAME_W-1:0] head_o,
    output logic               valid_o,
    output logic [AW:0]        level_o,
    output logic               drop_o
);

    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_q, wr_d;
    logic [AW:0]        rd_q, rd_d;
    logic [AW:0]        level;
    logic               empty, full, do_push, do_pop;

    assign level   = wr_q - rd_q;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign level_o = level;
    assign valid_o = !empty;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // Pointer next-state: flush beats everything; a pop frees a slot for a same-edge push when full.
    always_comb begin
        do_pop  = pop_i && !empty;
        do_push = push_i && !flush_i && (!full || do_pop);
        drop_o  = push_i && !flush_i && full && !do_pop;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + ONE;
            if (do_pop)  rd_d = rd_q + ONE;
        end
    end

    // Pointer and storage registers; storage is cleared so head fields read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/nec_ir_rx_ctrl.sv
// rtl/nec_ir_rx_ctrl.sv - NEC IR decoder sequencing and frame buffering controller (option: NEC_IR_RX_DROP_CNT_EN)
module nec_ir_rx_ctrl
    import nec_ir_pkg::*;
#(
    parameter int  DBITS = 32,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_repeat_en,
    input  logic [DBITS-1:0] cfg_delay_mask,
    input  logic             cfg_flush,
    input  logic [AW:0]      cfg_irq_thresh,
    input  logic             ovf_clr,
    output logic             dec_receiver_en,
    output logic             dec_repeat_en,
    output logic [DBITS-1:0] dec_delay_mask,
    input  logic [7:0]       frm_addr,
    input  logic [7:0]       frm_data,
    input  logic             frm_repeat,
    input  logic             frm_write,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_addr,
    output logic [7:0]       rx_data,
    output logic             rx_repeat,
    output logic [AW:0]      fill_level,
    output logic             overflow,
`ifdef NEC_IR_RX_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             irq
);

    nec_ir_rx_state_e state_q, state_d;
    logic             en_q, en_d;
    logic             rep_q, rep_d;
    logic [DBITS-1:0] mask_q, mask_d;
    logic             ovf_q;
    logic             fifo_push, fifo_drop;
    logic [FRAME_W-1:0] head_bits;
    nec_ir_frame_t    push_frm, head_frm;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= OFF;
        else     state_q <= state_d;
    end

    // Next state: any config difference while running forces a pass through LATCH,
    // which holds the decoder disabled for one cycle and flushes its in-flight frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (cfg_en) state_d = LATCH;
            LATCH:   state_d = RUN;
            RUN: begin
                if (!cfg_en)
                    state_d = OFF;
                else if ((cfg_repeat_en != rep_q) || (cfg_delay_mask != mask_q))
                    state_d = LATCH;
            end
            default: state_d = OFF;
        endcase
    end

    // Output next values: enable follows the upcoming state; shadows load only while latching.
    always_comb begin
        en_d   = (state_d == RUN);
        rep_d  = rep_q;
        mask_d = mask_q;
        if (state_q == LATCH) begin
            rep_d  = cfg_repeat_en;
            mask_d = cfg_delay_mask;
        end
    end

    // Registered decoder controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            rep_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            en_q   <= en_d;
            rep_q  <= rep_d;
            mask_q <= mask_d;
        end
    end

    assign dec_receiver_en = en_q;
    assign dec_repeat_en   = rep_q;
    assign dec_delay_mask  = mask_q;

    assign fifo_push = frm_write && (state_q == RUN);

    // Frame packing into the FIFO word.
    always_comb begin
        push_frm      = '0;
        push_frm.rep  = frm_repeat;
        push_frm.addr = frm_addr;
        push_frm.data = frm_data;
    end

    nec_ir_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_frm),
        .pop_i       (rx_ready),
        .flush_i     (cfg_flush),
        .head_o      (head_bits),
        .valid_o     (rx_valid),
        .level_o     (fill_level),
        .drop_o      (fifo_drop)
    );

    assign head_frm  = nec_ir_frame_t'(head_bits);
    assign rx_addr   = head_frm.addr;
    assign rx_data   = head_frm.data;
    assign rx_repeat = head_frm.rep;

    // Sticky overflow; a drop on the same edge as a clear leaves it set.
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= (ovf_q && !ovf_clr) || fifo_drop;
    end

    assign overflow = ovf_q;

`ifdef NEC_IR_RX_DROP_CNT_EN
    logic [7:0] cnt_q, cnt_base;

    assign cnt_base = ovf_clr ? 8'd0 : cnt_q;

    // Saturating drop counter; clear applies first so a same-edge drop counts as one.
    always_ff @(posedge clk) begin
        if (rst)                               cnt_q <= 8'd0;
        else if (fifo_drop && cnt_base != 8'hFF) cnt_q <= cnt_base + 8'd1;
        else                                   cnt_q <= cnt_base;
    end

    assign drop_cnt = cnt_q;
`endif

    assign irq = ((cfg_irq_thresh != '0) && (fill_level >= cfg_irq_thresh)) || ovf_q;

endmodule

// File: tb/tb_nec_ir_rx_ctrl.sv
// tb/tb_nec_ir_rx_ctrl.sv - self-checking bench for nec_ir_rx_ctrl
module tb_nec_ir_rx_ctrl;

    localparam int DBITS = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en, cfg_repeat_en, cfg_flush, ovf_clr;
    logic [31:0] cfg_delay_mask;
    logic [3:0]  cfg_irq_thresh;
    logic        dec_receiver_en, dec_repeat_en;
    logic [31:0] dec_delay_mask;
    logic [7:0]  frm_addr, frm_data;
    logic        frm_repeat, frm_write;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_addr, rx_data;
    logic        rx_repeat;
    logic [3:0]  fill_level;
    logic        overflow, irq;
`ifdef NEC_IR_RX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nec_ir_rx_ctrl #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_en          (cfg_en),
        .cfg_repeat_en   (cfg_repeat_en),
        .cfg_delay_mask  (cfg_delay_mask),
        .cfg_flush       (cfg_flush),
        .cfg_irq_thresh  (cfg_irq_thresh),
        .ovf_clr         (ovf_clr),
        .dec_receiver_en (dec_receiver_en),
        .dec_repeat_en   (dec_repeat_en),
        .dec_delay_mask  (dec_delay_mask),
        .frm_addr        (frm_addr),
        .frm_data        (frm_data),
        .frm_repeat      (frm_repeat),
        .frm_write       (frm_write),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_addr         (rx_addr),
        .rx_data         (rx_data),
        .rx_repeat       (rx_repeat),
        .fill_level      (fill_level),
        .overflow        (overflow),
`ifdef NEC_IR_RX_DROP_CNT_EN
        .drop_cnt        (drop_cnt),
`endif
        .irq             (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame queue plus an off/latching/running mode and sticky error state.
    logic [16:0] mq[$];
    int          m_mode = 0;      // 0 off, 1 latching, 2 running
    bit          m_rep  = 0;
    logic [31:0] m_mask = '0;
    bit          m_ovf  = 0;
    int          m_cnt  = 0;
    bit          m_live = 0;
    bit          m_drop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_mode = 0; m_rep = 0; m_mask = '0; m_ovf = 0; m_cnt = 0; m_live = 1;
        end else begin
            m_drop = 0;
            if (cfg_flush) begin
                mq.delete();
            end else begin
                if (rx_ready && mq.size() > 0) void'(mq.pop_front());
                if (frm_write && m_mode == 2) begin
                    if (mq.size() < DEPTH) mq.push_back({frm_repeat, frm_addr, frm_data});
                    else m_drop = 1;
                end
            end
            if (ovf_clr) begin m_ovf = 0; m_cnt = 0; end
            if (m_drop) begin
                m_ovf = 1;
                if (m_cnt < 255) m_cnt++;
            end
            case (m_mode)
                0: if (cfg_en) m_mode = 1;
                1: begin m_rep = cfg_repeat_en; m_mask = cfg_delay_mask; m_mode = 2; end
                default: begin
                    if (!cfg_en) m_mode = 0;
                    else if (cfg_repeat_en != m_rep || cfg_delay_mask != m_mask) m_mode = 1;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_dec_en",   dec_receiver_en, (m_mode == 2));
            chk("m_dec_rep",  dec_repeat_en, m_rep);
            chk("m_dec_mask", dec_delay_mask, m_mask);
            chk("m_rx_valid", rx_valid, (mq.size() > 0));
            chk("m_fill",     fill_level, mq.size());
            chk("m_overflow", overflow, m_ovf);
            chk("m_irq", irq, ((cfg_irq_thresh != 0 && mq.size() >= cfg_irq_thresh) || m_ovf));
            if (mq.size() > 0) chk("m_head", {rx_repeat, rx_addr, rx_data}, mq[0]);
`ifdef NEC_IR_RX_DROP_CNT_EN
            chk("m_drop_cnt", drop_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_addr;

    initial begin
        rst = 1; cfg_en = 0; cfg_repeat_en = 0; cfg_delay_mask = '0; cfg_flush = 0;
        cfg_irq_thresh = 0; ovf_clr = 0; frm_addr = 0; frm_data = 0; frm_repeat = 0;
        frm_write = 0; rx_ready = 0;
        tick(); tick();
        chk("rst_dec_en", dec_receiver_en, 0);
        chk("rst_mask",   dec_delay_mask, 0);
        chk("rst_valid",  rx_valid, 0);
        chk("rst_fill",   fill_level, 0);
        chk("rst_irq",    irq, 0);
        chk("rst_addr",   rx_addr, 0);
        rst = 0;

        // enable: one LATCH cycle with decoder off, then running
        cfg_en = 1; cfg_delay_mask = 32'hFF;
        tick();
        chk("en_latch_off", dec_receiver_en, 0);
        tick();
        chk("en_run_on", dec_receiver_en, 1);
        chk("en_mask",   dec_delay_mask, 32'hFF);

        // single frame, then pop
        frm_addr = 8'h12; frm_data = 8'h34; frm_write = 1;
        tick(); frm_write = 0;
        chk("one_valid", rx_valid, 1);
        chk("one_addr",  rx_addr, 8'h12);
        chk("one_data",  rx_data, 8'h34);
        chk("one_fill",  fill_level, 1);
        rx_ready = 1; tick(); rx_ready = 0;
        chk("one_popped", fill_level, 0);

        // nine pushes into eight slots
        for (int i = 0; i < 9; i++) begin
            frm_addr = 8'h20 + 8'(i); frm_data = 8'hA0 + 8'(i); frm_write = 1;
            tick();
        end
        frm_write = 0;
        chk("full_fill", fill_level, 8);
        chk("full_ovf",  overflow, 1);
        chk("full_irq",  irq, 1);
        chk("full_head", rx_addr, 8'h20);
`ifdef NEC_IR_RX_DROP_CNT_EN
        chk("full_drops", drop_cnt, 1);
`endif
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("ovf_cleared", overflow, 0);

        // full with simultaneous push and pop
        frm_addr = 8'h55; frm_data = 8'h5A; frm_write = 1; rx_ready = 1;
        tick(); frm_write = 0; rx_ready = 0;
        chk("fpp_fill", fill_level, 8);
        chk("fpp_ovf",  overflow, 0);
        for (int k = 0; k < 8; k++) begin
            exp_addr = (k < 7) ? 8'h21 + 8'(k) : 8'h55;
            chk("fpp_order", rx_addr, exp_addr);
            rx_ready = 1; tick();
        end
        rx_ready = 0;
        chk("drained", fill_level, 0);

        // reconfig while running: one disabled cycle, write during it ignored
        frm_addr = 8'h66; frm_data = 8'h01; frm_write = 1; tick(); frm_write = 0;
        cfg_delay_mask = 32'h0F;
        tick();
        chk("rcfg_off", dec_receiver_en, 0);
        frm_addr = 8'h77; frm_write = 1; tick(); frm_write = 0;
        chk("rcfg_on",   dec_receiver_en, 1);
        chk("rcfg_mask", dec_delay_mask, 32'h0F);
        chk("rcfg_fill", fill_level, 1);
        chk("rcfg_head", rx_addr, 8'h66);
        tick();
        chk("rcfg_stay", dec_receiver_en, 1);

        // flush discards contents and a same-cycle push
        frm_addr = 8'h88; frm_write = 1; cfg_flush = 1; tick(); frm_write = 0; cfg_flush = 0;
        chk("flush_valid", rx_valid, 0);
        chk("flush_fill",  fill_level, 0);

        // threshold interrupt
        cfg_irq_thresh = 3;
        for (int i = 0; i < 3; i++) begin
            frm_addr = 8'h90 + 8'(i); frm_write = 1; tick();
            chk("thr_irq", irq, (i == 2));
        end
        frm_write = 0;
        rx_ready = 1; tick(); rx_ready = 0;
        chk("thr_irq_pop", irq, 0);
        cfg_irq_thresh = 0;

        // disable: writes ignored while off, contents kept
        cfg_en = 0; tick();
        chk("off_en", dec_receiver_en, 0);
        frm_write = 1; tick(); frm_write = 0;
        chk("off_fill", fill_level, 2);
        cfg_en = 1; tick(); tick();

        // mixed traffic checked by the model
        for (int c = 0; c < 300; c++) begin
            frm_write      = ($urandom_range(0, 1) == 1);
            frm_addr       = 8'($urandom);
            frm_data       = 8'($urandom);
            frm_repeat     = 1'($urandom);
            rx_ready       = ($urandom_range(0, 9) < 3);
            cfg_flush      = ($urandom_range(0, 49) == 0);
            ovf_clr        = ($urandom_range(0, 19) == 0);
            cfg_irq_thresh = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0) cfg_repeat_en = ~cfg_repeat_en;
            tick();
        end
        frm_write = 0; rx_ready = 0; cfg_flush = 0; ovf_clr = 0;

        // reset mid-run
        frm_addr = 8'hC3; frm_write = 1; tick(); frm_write = 0;
        rst = 1; tick();
        chk("mid_rst_en",    dec_receiver_en, 0);
        chk("mid_rst_rep",   dec_repeat_en, 0);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_fill",  fill_level, 0);
        chk("mid_rst_ovf",   overflow, 0);
        chk("mid_rst_irq",   irq, 0);
        chk("mid_rst_addr",  rx_addr, 0);
        rst = 0; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
